// File: rtl/mod_enc_keyexpand_if.sv
// Bus bundle for the AES-256 key expander: start/key in, round-key stream out,
// and the optional round-key cache read port.
interface mod_enc_keyexpand_if;
    logic         start;
    logic [255:0] key;
    logic [127:0] rk;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic         rk_rd;
    logic [3:0]   rk_sel;
    logic [127:0] rk_rd_data;

    modport master (output start, key, rk_ready, rk_rd, rk_sel,
                    input  rk, rk_valid, rk_idx, busy, done, rk_rd_data);
    modport slave  (input  start, key, rk_ready, rk_rd, rk_sel,
                    output rk, rk_valid, rk_idx, busy, done, rk_rd_data);
endinterface

// File: rtl/mod_enc_keyexpand.sv
// AES-256 key expander streaming 15 round keys over a valid/ready handshake.
// Define KEYEXPAND_CACHE_EN to add a 15-entry round-key cache readable in DONE.
module mod_enc_keyexpand (
    input  logic               clk,
    input  logic               resetn,
    mod_enc_keyexpand_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0][31:0]   r_win;
    logic [127:0]       r_rk;
    logic [3:0]         r_idx;
    logic               w_load;
    logic               w_hs;
    logic [3:0]         w_rnd;
    logic               w_even;
    logic [7:0]         w_rcon;
    logic [31:0]        w_sub_in;
    logic [31:0]        w_sub_out;
    logic [31:0]        w_temp;
    logic [3:0][31:0]   w_new;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        // NOTE: function-local temporaries use blocking '='; only clocked state uses '<='.
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: inverse as a^254 (zero maps to zero), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_EXPAND;
                    w_load      = 1'b1;
                end
            end
            ST_EXPAND: begin
                w_hs = bus.rk_ready;
                if (bus.rk_ready && r_idx == 4'd14) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.rk_valid = (r_state == ST_EXPAND);
    assign bus.busy     = (r_state == ST_EXPAND);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.rk       = r_rk;
    assign bus.rk_idx   = r_idx;

    // Even rounds start a new 8-word block: rotate and add Rcon; odd rounds only substitute.
    always_comb begin
        w_rnd  = r_idx + 4'd1;
        w_even = ~w_rnd[0];
        case (w_rnd[3:1])
            3'd1:    w_rcon = 8'h01;
            3'd2:    w_rcon = 8'h02;
            3'd3:    w_rcon = 8'h04;
            3'd4:    w_rcon = 8'h08;
            3'd5:    w_rcon = 8'h10;
            3'd6:    w_rcon = 8'h20;
            3'd7:    w_rcon = 8'h40;
            default: w_rcon = 8'h00;
        endcase
        w_sub_in = w_even ? {r_win[7][7:0], r_win[7][31:8]} : r_win[7];
        for (int j = 0; j < 4; j++) w_sub_out[8*j +: 8] = sbox(w_sub_in[8*j +: 8]);
        w_temp   = w_sub_out ^ (w_even ? {24'h000000, w_rcon} : 32'h00000000);
        w_new[0] = r_win[0] ^ w_temp;
        w_new[1] = r_win[1] ^ w_new[0];
        w_new[2] = r_win[2] ^ w_new[1];
        w_new[3] = r_win[3] ^ w_new[2];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_win <= '0;
            r_rk  <= '0;
            r_idx <= '0;
        end else if (w_load) begin
            r_win <= bus.key;
            r_rk  <= bus.key[127:0];
            r_idx <= 4'd0;
        end else if (w_hs && r_idx != 4'd14) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd0) begin
                r_rk <= r_win[7:4];
            end else begin
                r_rk  <= w_new;
                r_win <= {w_new, r_win[7:4]};
            end
        end
    end

`ifdef KEYEXPAND_CACHE_EN
    logic [127:0] r_cache [15];
    logic [127:0] r_rd_data;

    // NOTE: the storage array is deliberately not reset; the read register alone guards its output.
    always_ff @(posedge clk) begin
        if (w_hs) r_cache[r_idx] <= r_rk;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (r_state == ST_DONE && bus.rk_rd) begin
            r_rd_data <= (bus.rk_sel <= 4'd14) ? r_cache[bus.rk_sel] : '0;
        end
    end

    assign bus.rk_rd_data = r_rd_data;
`else
    logic w_unused_rd;
    assign w_unused_rd    = ^{bus.rk_rd, bus.rk_sel};
    assign bus.rk_rd_data = '0;
`endif

endmodule

// File: tb/tb_mod_enc_keyexpand.sv
// Directed bench for mod_enc_keyexpand: FIPS-197 A.3 schedule, stalls, ignored start,
// mid-run reset, zero key and (with KEYEXPAND_CACHE_EN) cache reads.
module tb_mod_enc_keyexpand;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mod_enc_keyexpand_if u_if ();
    mod_enc_keyexpand u_dut (.clk(clk), .resetn(resetn), .bus(u_if));

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] fips;
    } vec_t;

    vec_t         a3 [15];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] a3_key_fips = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // FIPS text lists byte 0 first (leftmost); the DUT holds byte 0 in the LSBs.
    function automatic logic [127:0] to_rk(input logic [127:0] f);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = f[127-8*j -: 8];
        return r;
    endfunction

    function automatic logic [255:0] to_key(input logic [255:0] f);
        logic [255:0] r;
        for (int j = 0; j < 32; j++) r[8*j +: 8] = f[255-8*j -: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [255:0] key_fips);
        u_if.key   = to_key(key_fips);
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
    endtask

    task automatic check_key(input string tag, input int k);
        check($sformatf("%s_valid%0d", tag, k), {127'd0, u_if.rk_valid}, 128'd1);
        check($sformatf("%s_idx%0d", tag, k), {124'd0, u_if.rk_idx}, {124'd0, a3[k].idx});
        check($sformatf("%s_rk%0d", tag, k), u_if.rk, to_rk(a3[k].fips));
    endtask

    initial begin
        a3[0]  = '{4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        a3[1]  = '{4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
        a3[2]  = '{4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        a3[3]  = '{4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a};
        a3[4]  = '{4'd4,  128'hd59aecb85bf3c917fee94248de8ebe96};
        a3[5]  = '{4'd5,  128'hb5a9328a2678a647983122292f6c79b3};
        a3[6]  = '{4'd6,  128'h812c81addadf48ba24360af2fab8b464};
        a3[7]  = '{4'd7,  128'h98c5bfc9bebd198e268c3ba709e04214};
        a3[8]  = '{4'd8,  128'h68007bacb2df331696e939e46c518d80};
        a3[9]  = '{4'd9,  128'hc814e20476a9fb8a5025c02d59c58239};
        a3[10] = '{4'd10, 128'hde1369676ccc5a71fa2563959674ee15};
        a3[11] = '{4'd11, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3};
        a3[12] = '{4'd12, 128'h749c47ab18501ddae2757e4f7401905a};
        a3[13] = '{4'd13, 128'hcafaaae3e4d59b349adf6acebd10190d};
        a3[14] = '{4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

        u_if.start    = 1'b0;
        u_if.key      = '0;
        u_if.rk_ready = 1'b0;
        u_if.rk_rd    = 1'b0;
        u_if.rk_sel   = 4'd0;
        resetn        = 1'b0;
        tick();
        tick();
        check("rst_rk",      u_if.rk, 128'd0);
        check("rst_idx",     {124'd0, u_if.rk_idx}, 128'd0);
        check("rst_valid",   {127'd0, u_if.rk_valid}, 128'd0);
        check("rst_busy",    {127'd0, u_if.busy}, 128'd0);
        check("rst_done",    {127'd0, u_if.done}, 128'd0);
        check("rst_rd_data", u_if.rk_rd_data, 128'd0);
        resetn = 1'b1;
        tick();
        check("idle_valid", {127'd0, u_if.rk_valid}, 128'd0);

        // Full-rate A.3 run: 15 keys in 15 cycles.
        u_if.rk_ready = 1'b1;
        do_start(a3_key_fips);
        for (int k = 0; k < 15; k++) begin
            check_key("a3", k);
            if (k == 3) check("a3_busy", {127'd0, u_if.busy}, 128'd1);
            tick();
        end
        check("a3_done",     {127'd0, u_if.done}, 128'd1);
        check("a3_end_valid", {127'd0, u_if.rk_valid}, 128'd0);
        check("a3_end_busy", {127'd0, u_if.busy}, 128'd0);
        check("a3_end_rk",   u_if.rk, to_rk(a3[14].fips));
        tick();
        check("a3_done_hold_valid", {127'd0, u_if.rk_valid}, 128'd0);

        // Ready pattern 1,0,0,1: keys must hold through stalls.
        begin
            logic [3:0] pat;
            logic       rdy;
            int         k;
            int         c;
            pat = 4'b1001;
            k   = 0;
            c   = 0;
            do_start(a3_key_fips);
            while (k < 15 && c < 100) begin
                rdy           = pat[c % 4];
                u_if.rk_ready = rdy;
                check_key("stall", k);
                tick();
                if (rdy) k++;
                c++;
            end
            check("stall_keys",   k, 15);
            check("stall_cycles", c, 29);
            check("stall_done",   {127'd0, u_if.done}, 128'd1);
        end

        // start pulsed (with a different key) at idx 5 must be ignored.
        u_if.rk_ready = 1'b1;
        do_start(a3_key_fips);
        for (int k = 0; k < 15; k++) begin
            check_key("ign", k);
            if (k == 5) begin
                u_if.start = 1'b1;
                u_if.key   = '0;
            end else begin
                u_if.start = 1'b0;
            end
            tick();
        end
        u_if.start = 1'b0;
        check("ign_done", {127'd0, u_if.done}, 128'd1);

        // Reset at idx 7, then a fresh all-zero key.
        do_start(a3_key_fips);
        for (int k = 0; k < 7; k++) tick();
        check_key("prerst", 7);
        resetn = 1'b0;
        #1;
        check("mrst_rk",      u_if.rk, 128'd0);
        check("mrst_idx",     {124'd0, u_if.rk_idx}, 128'd0);
        check("mrst_valid",   {127'd0, u_if.rk_valid}, 128'd0);
        check("mrst_busy",    {127'd0, u_if.busy}, 128'd0);
        check("mrst_done",    {127'd0, u_if.done}, 128'd0);
        check("mrst_rd_data", u_if.rk_rd_data, 128'd0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_valid%0d", i), {127'd0, u_if.rk_valid}, 128'd0);
            check($sformatf("post_rst_busy%0d", i),  {127'd0, u_if.busy}, 128'd0);
        end
        u_if.rk_rd  = 1'b1;
        u_if.rk_sel = 4'd14;
        tick();
        u_if.rk_rd  = 1'b0;
        check("idle_rd_zero", u_if.rk_rd_data, 128'd0);

        do_start(256'd0);
        check("zero_rk0", u_if.rk, 128'd0);
        tick();
        check("zero_rk1", u_if.rk, 128'd0);
        check("zero_idx1", {124'd0, u_if.rk_idx}, 128'd1);
        tick();
        check("zero_rk2", u_if.rk, to_rk(128'h62636363626363636263636362636363));
        check("zero_idx2", {124'd0, u_if.rk_idx}, 128'd2);
        begin
            int c;
            c = 0;
            while (!u_if.done && c < 40) begin
                tick();
                c++;
            end
            check("zero_done", {127'd0, u_if.done}, 128'd1);
        end

        // Cache reads after a complete A.3 run.
        do_start(a3_key_fips);
        for (int k = 0; k < 15; k++) tick();
        check("cache_run_done", {127'd0, u_if.done}, 128'd1);
        u_if.rk_rd  = 1'b1;
        u_if.rk_sel = 4'd14;
        tick();
`ifdef KEYEXPAND_CACHE_EN
        check("cache_sel14", u_if.rk_rd_data, to_rk(a3[14].fips));
        u_if.rk_sel = 4'd0;
        tick();
        check("cache_sel0", u_if.rk_rd_data, to_rk(a3[0].fips));
        u_if.rk_sel = 4'd7;
        tick();
        check("cache_sel7", u_if.rk_rd_data, to_rk(a3[7].fips));
        u_if.rk_sel = 4'd15;
        tick();
        check("cache_sel15", u_if.rk_rd_data, 128'd0);
        u_if.rk_sel = 4'd2;
        tick();
        check("cache_sel2", u_if.rk_rd_data, to_rk(a3[2].fips));
        u_if.rk_rd  = 1'b0;
        u_if.rk_sel = 4'd9;
        tick();
        check("cache_hold", u_if.rk_rd_data, to_rk(a3[2].fips));
`else
        check("nocache_sel14", u_if.rk_rd_data, 128'd0);
        u_if.rk_sel = 4'd0;
        tick();
        check("nocache_sel0", u_if.rk_rd_data, 128'd0);
        u_if.rk_rd = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
